disp_demux: RTL and testbench

- Receive-side counterpart of the team's 4-digit display multiplexer.
- Samples the time-multiplexed anode/segment bus (an, sseg) and rebuilds the four per-digit 8-bit segment patterns.
- Flags completed scan frames and illegal anode codes.
- Used in loopback self-check of the display path, and to capture display traffic from an external board.

---
 rtl/disp_demux.sv | 131 +++++++++++++
 tb/tb_disp_demux.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/disp_demux.sv
// Receive side of the 4-digit display multiplexer: samples the anode/segment
// bus, rebuilds the four digit patterns, flags finished frames and bad anodes.
module disp_demux #(
    parameter int SETTLE = 1,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [7:0] out3,
    output logic [7:0] out2,
    output logic [7:0] out1,
    output logic [7:0] out0,
    output logic [3:0] valid,
    output logic [1:0] cur_digit,
    output logic       frame_done,
    output logic       err
);

    localparam logic [CW-1:0] HOLD_CAP = CW'(SETTLE);
    localparam logic [CW-1:0] HOLD_MAX = CW'(SETTLE + 1);

    logic [3:0]    an_q;
    logic [7:0]    sseg_q;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    seen_q, seen_d;
    logic [7:0]    out_q [4];
    logic [7:0]    out_d [4];
    logic [3:0]    valid_q, valid_d;
    logic [1:0]    cur_q, cur_d;
    logic          fd_q, fd_d;
    logic          err_q, err_d;

    logic          legal, blank, illegal, capture;
    logic [1:0]    k;
    logic [3:0]    seen_set;

    // Decode the registered anode code: one zero bit selects digit k.
    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        k     = 2'd0;
        case (an_q)
            4'b1110: k = 2'd0;
            4'b1101: k = 2'd1;
            4'b1011: k = 2'd2;
            4'b0111: k = 2'd3;
            4'b1111: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign illegal  = !legal && !blank;
    assign capture  = legal && (hcnt_q == HOLD_CAP);
    assign seen_set = seen_q | (4'b0001 << k);

    // Saturating at SETTLE+1 keeps the capture to a single edge per hold.
    always_comb begin
        if (an != an_q) begin
            hcnt_d = CW'(1);
        end else if (hcnt_q == HOLD_MAX) begin
            hcnt_d = hcnt_q;
        end else begin
            hcnt_d = hcnt_q + CW'(1);
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        cur_d   = cur_q;
        seen_d  = seen_q;
        fd_d    = 1'b0;
        err_d   = err_q;
        if (illegal) begin
            err_d  = 1'b1;
            seen_d = 4'b0000;
        end else if (capture) begin
            out_d[k]   = sseg_q;
            valid_d[k] = 1'b1;
            cur_d      = k;
            if (seen_set == 4'b1111) begin
                fd_d   = 1'b1;
                seen_d = 4'b0000;
            end else begin
                seen_d = seen_set;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an_q     <= 4'b1111;
            sseg_q   <= 8'hFF;
            hcnt_q   <= '0;
            seen_q   <= 4'b0000;
            out_q[0] <= 8'hFF;
            out_q[1] <= 8'hFF;
            out_q[2] <= 8'hFF;
            out_q[3] <= 8'hFF;
            valid_q  <= 4'b0000;
            cur_q    <= 2'd0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            an_q     <= an;
            sseg_q   <= sseg;
            hcnt_q   <= hcnt_d;
            seen_q   <= seen_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            cur_q    <= cur_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign out2       = out_q[2];
    assign out3       = out_q[3];
    assign valid      = valid_q;
    assign cur_digit  = cur_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_disp_demux.sv
// Directed bench for disp_demux: three instances (SETTLE = 1, 2, 3) share one
// stimulus bus; each scenario checks the instance whose settle time it targets.
module tb_disp_demux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] an = 4'b1111;
  logic [7:0] sseg = 8'hFF;

  logic [7:0] out3_w [3];
  logic [7:0] out2_w [3];
  logic [7:0] out1_w [3];
  logic [7:0] out0_w [3];
  logic [3:0] valid_w [3];
  logic [1:0] cur_w [3];
  logic       fd_w [3];
  logic       err_w [3];

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Instance g uses SETTLE = g + 1.
  for (genvar g = 0; g < 3; g++) begin : gi
    disp_demux #(.SETTLE(g + 1), .CW(4)) u_dut (
      .clk(clk),
      .reset(reset),
      .an(an),
      .sseg(sseg),
      .out3(out3_w[g]),
      .out2(out2_w[g]),
      .out1(out1_w[g]),
      .out0(out0_w[g]),
      .valid(valid_w[g]),
      .cur_digit(cur_w[g]),
      .frame_done(fd_w[g]),
      .err(err_w[g])
    );
  end

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    an = a;
    sseg = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(4'b1111, 8'hFF);
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out0", out0_w[0], 8'hFF);
    check("rst_out3", out3_w[0], 8'hFF);
    check("rst_valid", {4'h0, valid_w[0]}, 8'h00);
    check("rst_cur", {6'd0, cur_w[0]}, 8'h00);
    check("rst_fd", {7'd0, fd_w[0]}, 8'h00);
    check("rst_err", {7'd0, err_w[0]}, 8'h00);

    // Loopback scan with 1-cycle holds, SETTLE=1
    step(4'b1110, 8'h66);
    check("lb_none", {4'h0, valid_w[0]}, 8'h00);
    step(4'b1101, 8'hF0);
    check("lb_out0", out0_w[0], 8'h66);
    check("lb_v1", {4'h0, valid_w[0]}, 8'h01);
    step(4'b1011, 8'hAA);
    check("lb_out1", out1_w[0], 8'hF0);
    step(4'b0111, 8'hCC);
    check("lb_out2", out2_w[0], 8'hAA);
    check("lb_fd_pre", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1110, 8'h66);
    check("lb_out3", out3_w[0], 8'hCC);
    check("lb_fd1", {7'd0, fd_w[0]}, 8'h01);
    check("lb_cur3", {6'd0, cur_w[0]}, 8'h03);
    check("lb_valid", {4'h0, valid_w[0]}, 8'h0F);
    step(4'b1101, 8'hF0);
    check("lb_fd_gap1", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1011, 8'hAA);
    check("lb_fd_gap2", {7'd0, fd_w[0]}, 8'h00);
    step(4'b0111, 8'hCC);
    check("lb_fd_gap3", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1110, 8'h66);
    check("lb_fd2", {7'd0, fd_w[0]}, 8'h01);
    check("lb_err", {7'd0, err_w[0]}, 8'h00);
    check("lb_s2_nocap", {4'h0, valid_w[1]}, 8'h00);

    // Settle filtering, SETTLE=3
    do_reset();
    step(4'b1110, 8'h66);
    step(4'b1110, 8'h66);
    step(4'b1101, 8'hF0);
    step(4'b1101, 8'hF0);
    step(4'b1101, 8'hF0);
    check("sf_early", {4'h0, valid_w[2]}, 8'h00);
    step(4'b1101, 8'hF0);
    check("sf_out1", out1_w[2], 8'hF0);
    check("sf_out0", out0_w[2], 8'hFF);
    check("sf_valid", {4'h0, valid_w[2]}, 8'h02);

    // Mid-hold sseg change, SETTLE=2
    do_reset();
    step(4'b1011, 8'hAA);
    step(4'b1011, 8'hAA);
    check("mh_early", {4'h0, valid_w[1]}, 8'h00);
    step(4'b1011, 8'h55);
    check("mh_cap", out2_w[1], 8'hAA);
    check("mh_valid", {4'h0, valid_w[1]}, 8'h04);
    check("mh_cur", {6'd0, cur_w[1]}, 8'h02);
    step(4'b1011, 8'h55);
    step(4'b1011, 8'h55);
    check("mh_keep", out2_w[1], 8'hAA);

    // Illegal anode code, SETTLE=1
    do_reset();
    step(4'b1110, 8'h01);
    step(4'b1101, 8'h02);
    step(4'b1100, 8'h03);
    check("il_err0", {7'd0, err_w[0]}, 8'h00);
    check("il_out1", out1_w[0], 8'h02);
    step(4'b1011, 8'h04);
    check("il_err1", {7'd0, err_w[0]}, 8'h01);
    step(4'b0111, 8'h05);
    check("il_out2", out2_w[0], 8'h04);
    step(4'b1111, 8'hFF);
    check("il_out3", out3_w[0], 8'h05);
    check("il_nofd", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1110, 8'h11);
    step(4'b1101, 8'h12);
    check("il_nofd2", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1111, 8'hFF);
    check("il_fd", {7'd0, fd_w[0]}, 8'h01);
    check("il_out1b", out1_w[0], 8'h12);
    check("il_sticky", {7'd0, err_w[0]}, 8'h01);

    // Blank code and scan order, SETTLE=1
    do_reset();
    step(4'b1110, 8'hA1);
    step(4'b1111, 8'hA2);
    step(4'b0111, 8'hA3);
    step(4'b1101, 8'hA4);
    step(4'b1011, 8'hA5);
    check("bo_nofd", {7'd0, fd_w[0]}, 8'h00);
    step(4'b1111, 8'hFF);
    check("bo_fd", {7'd0, fd_w[0]}, 8'h01);
    check("bo_cur", {6'd0, cur_w[0]}, 8'h02);
    check("bo_err", {7'd0, err_w[0]}, 8'h00);
    check("bo_out0", out0_w[0], 8'hA1);
    check("bo_out3", out3_w[0], 8'hA3);
    check("bo_out1", out1_w[0], 8'hA4);
    check("bo_out2", out2_w[0], 8'hA5);

    // Reset mid-frame, SETTLE=1
    do_reset();
    step(4'b1110, 8'hB0);
    step(4'b1101, 8'hB1);
    step(4'b1011, 8'hB2);
    step(4'b1111, 8'hFF);
    check("rm_pre", {4'h0, valid_w[0]}, 8'h07);
    do_reset();
    check("rm_out0", out0_w[0], 8'hFF);
    check("rm_valid", {4'h0, valid_w[0]}, 8'h00);
    step(4'b0111, 8'hB3);
    step(4'b1111, 8'hFF);
    check("rm_v3", {4'h0, valid_w[0]}, 8'h08);
    check("rm_nofd", {7'd0, fd_w[0]}, 8'h00);
    check("rm_out3", out3_w[0], 8'hB3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
